// File: rtl/display_scheduler_if.sv
// Bundle between the display requesters and the scheduler.
// master = requester side, slave = scheduler side.
interface display_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   value;
    logic [NREQ-1:0]      grant;
    logic [1:0]           owner;
    logic [15:0]          disp_value;
    logic                 disp_blank;
    logic                 switch_pulse;

    modport master (
        output req, value,
        input  grant, owner, disp_value, disp_blank, switch_pulse
    );

    modport slave (
        input  req, value,
        output grant, owner, disp_value, disp_blank, switch_pulse
    );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin owner scheduler for the shared 4-digit display, with minimum dwell
// and a blanking gap between owners. Define DISP_SCHED_PRIO_EN for requester-0 priority.
module display_scheduler #(
    parameter int          NREQ  = 4,
    parameter logic [15:0] DWELL = 16'd5000,
    parameter logic [7:0]  BLANK = 8'd4
) (
    input logic          clk,
    input logic          rst,
    display_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_OPEN  = 2'd2,
        S_BLANK = 2'd3
    } state_t;

    localparam logic [15:0] DWELL_LAST = DWELL - 16'd1;
    localparam logic [7:0]  BLANK_LAST = BLANK - 8'd1;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        next_q, next_d;
    logic [15:0]       dwell_q, dwell_d;
    logic [7:0]        blank_q, blank_d;
    logic [15:0]       disp_value_q, disp_value_d;
    logic              disp_blank_q;
    logic              switch_q, switch_d;

    logic [3:0]        req_pad;
    logic [3:0]        grant_pad;
    logic [63:0]       value_pad;
    logic [2:0]        pick_all;
    logic [2:0]        pick_other;
    logic              do_grant, do_switch;
    logic [1:0]        grant_idx, switch_idx;
    logic [3:0]        onehot;

    // Returns {found, index}: first asserted request at or after start, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] pick;
        int j;
        pick = 3'b000;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= NREQ) j = j - NREQ;
            if (r[2'(j)]) pick = {1'b1, 2'(j)};
        end
`ifdef DISP_SCHED_PRIO_EN
        if (r[0]) pick = 3'b100;
`endif
        return pick;
    endfunction

    assign req_pad    = 4'(bus.req);
    assign grant_pad  = 4'(grant_q);
    assign value_pad  = 64'(bus.value);
    assign pick_all   = rr_pick(req_pad, ptr_q);
    // The current owner is masked so a switch always lands on someone else.
    assign pick_other = rr_pick(req_pad & ~grant_pad, ptr_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        next_d       = next_q;
        dwell_d      = dwell_q;
        blank_d      = blank_q;
        disp_value_d = disp_value_q;
        switch_d     = 1'b0;
        do_grant     = 1'b0;
        grant_idx    = 2'd0;
        do_switch    = 1'b0;
        switch_idx   = 2'd0;
        onehot       = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (pick_all[2]) begin
                    do_grant  = 1'b1;
                    grant_idx = pick_all[1:0];
                end
            end
            S_DWELL, S_OPEN: begin
                if (!req_pad[owner_q]) begin
                    if (pick_other[2]) begin
                        do_switch  = 1'b1;
                        switch_idx = pick_other[1:0];
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end
`ifdef DISP_SCHED_PRIO_EN
                else if (owner_q != 2'd0 && req_pad[0]) begin
                    do_switch  = 1'b1;
                    switch_idx = 2'd0;
                end
`endif
                // The last dwell cycle already follows the open-state rules.
                else if (state_q == S_OPEN || dwell_q == DWELL_LAST) begin
                    if (pick_other[2]) begin
                        do_switch  = 1'b1;
                        switch_idx = pick_other[1:0];
                    end else begin
                        state_d = S_OPEN;
                    end
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            S_BLANK: begin
                if (blank_q == BLANK_LAST) begin
                    if (req_pad[next_q]) begin
                        do_grant  = 1'b1;
                        grant_idx = next_q;
                    end else if (pick_all[2]) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_all[1:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    blank_d = blank_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (do_switch) begin
            if (BLANK == 8'd0) begin
                do_grant  = 1'b1;
                grant_idx = switch_idx;
            end else begin
                state_d = S_BLANK;
                grant_d = '0;
                next_d  = switch_idx;
                blank_d = 8'd0;
            end
        end

        if (do_grant) begin
            onehot   = 4'b0001 << grant_idx;
            state_d  = S_DWELL;
            grant_d  = onehot[NREQ-1:0];
            owner_d  = grant_idx;
            ptr_d    = (int'(grant_idx) == NREQ - 1) ? 2'd0 : grant_idx + 2'd1;
            dwell_d  = 16'd0;
            switch_d = 1'b1;
        end

        if (grant_d != '0) disp_value_d = value_pad[{owner_d, 4'b0000} +: 16];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            owner_q      <= 2'd0;
            ptr_q        <= 2'd0;
            next_q       <= 2'd0;
            dwell_q      <= 16'd0;
            blank_q      <= 8'd0;
            disp_value_q <= 16'h0000;
            disp_blank_q <= 1'b1;
            switch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            next_q       <= next_d;
            dwell_q      <= dwell_d;
            blank_q      <= blank_d;
            disp_value_q <= disp_value_d;
            disp_blank_q <= (grant_d == '0);
            switch_q     <= switch_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.owner        = owner_q;
    assign bus.disp_value   = disp_value_q;
    assign bus.disp_blank   = disp_blank_q;
    assign bus.switch_pulse = switch_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: cycle table with scoreboard queue,
// plus hand sequences for BLANK=0 / NREQ=3 and asynchronous reset.
module tb_display_scheduler;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] v2;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        blank;
        logic        sw;
        logic [15:0] dval;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    vec_t vecs[$];
    vec_t exp_q[$];

    display_scheduler_if #(.NREQ(4)) bus ();
    display_scheduler_if #(.NREQ(3)) bus_b ();

    display_scheduler #(.NREQ(4), .DWELL(16'd8), .BLANK(8'd2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    display_scheduler #(.NREQ(3), .DWELL(16'd2), .BLANK(8'd0)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_rows(input int n, input logic [3:0] r, input logic [15:0] v2,
                            input logic [3:0] g, input logic [1:0] o, input logic b,
                            input logic s, input logic [15:0] d);
        vec_t t;
        t.req = r; t.v2 = v2; t.grant = g; t.owner = o; t.blank = b; t.sw = s; t.dval = d;
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.req   = v.req;
        bus.value = {16'h3333, v.v2, 16'h2222, 16'h1111};
        exp_q.push_back(v);
    endtask

    task automatic check_output(input int row);
        vec_t e;
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("[TB] FAIL row%0d scoreboard empty", row);
        end else begin
            e = exp_q.pop_front();
            if (bus.grant !== e.grant || bus.owner !== e.owner || bus.disp_blank !== e.blank ||
                bus.switch_pulse !== e.sw || bus.disp_value !== e.dval) begin
                failed++;
                $display("[TB] FAIL row%0d got grant=%b owner=%0d blank=%b sw=%b val=%h, want grant=%b owner=%0d blank=%b sw=%b val=%h",
                         row, bus.grant, bus.owner, bus.disp_blank, bus.switch_pulse, bus.disp_value,
                         e.grant, e.owner, e.blank, e.sw, e.dval);
            end
        end
    endtask

    task automatic check_main(input string name, input logic [3:0] g, input logic [1:0] o,
                              input logic b, input logic s, input logic [15:0] d);
        tests++;
        if (bus.grant !== g || bus.owner !== o || bus.disp_blank !== b ||
            bus.switch_pulse !== s || bus.disp_value !== d) begin
            failed++;
            $display("[TB] FAIL %s got grant=%b owner=%0d blank=%b sw=%b val=%h, want grant=%b owner=%0d blank=%b sw=%b val=%h",
                     name, bus.grant, bus.owner, bus.disp_blank, bus.switch_pulse, bus.disp_value,
                     g, o, b, s, d);
        end
    endtask

    task automatic step_b(input string name, input logic [2:0] r, input logic [2:0] g,
                          input logic s, input logic [15:0] d);
        bus_b.req = r;
        @(posedge clk);
        #1;
        tests++;
        if (bus_b.grant !== g || bus_b.switch_pulse !== s || bus_b.disp_value !== d ||
            bus_b.disp_blank !== (g == 3'b000)) begin
            failed++;
            $display("[TB] FAIL %s got grant=%b sw=%b blank=%b val=%h, want grant=%b sw=%b blank=%b val=%h",
                     name, bus_b.grant, bus_b.switch_pulse, bus_b.disp_blank, bus_b.disp_value,
                     g, s, (g == 3'b000), d);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tests  = 0;
        failed = 0;

        // Reset / first grant
        add_rows(1, 4'b1111, 16'hBEEF, 4'b0001, 2'd0, 1'b0, 1'b1, 16'h1111);
        add_rows(1, 4'b0000, 16'hBEEF, 4'b0000, 2'd0, 1'b1, 1'b0, 16'h1111);
        // Single owner, live value tracking
        add_rows(1,  4'b0100, 16'hBEEF, 4'b0100, 2'd2, 1'b0, 1'b1, 16'hBEEF);
        add_rows(10, 4'b0100, 16'hBEEF, 4'b0100, 2'd2, 1'b0, 1'b0, 16'hBEEF);
        add_rows(2,  4'b0100, 16'h1234, 4'b0100, 2'd2, 1'b0, 1'b0, 16'h1234);
        add_rows(1,  4'b0000, 16'h1234, 4'b0000, 2'd2, 1'b1, 1'b0, 16'h1234);
        // Dwell and rotation between 0 and 1
`ifdef DISP_SCHED_PRIO_EN
        add_rows(1, 4'b0011, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b1, 16'h1111);
        add_rows(7, 4'b0011, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b0, 16'h1111);
        add_rows(2, 4'b0011, 16'h1234, 4'b0000, 2'd0, 1'b1, 1'b0, 16'h1111);
        add_rows(1, 4'b0011, 16'h1234, 4'b0010, 2'd1, 1'b0, 1'b1, 16'h2222);
        add_rows(2, 4'b0011, 16'h1234, 4'b0000, 2'd1, 1'b1, 1'b0, 16'h2222);
        add_rows(1, 4'b0011, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b1, 16'h1111);
        add_rows(7, 4'b0011, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b0, 16'h1111);
`else
        add_rows(1, 4'b0011, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b1, 16'h1111);
        add_rows(7, 4'b0011, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b0, 16'h1111);
        add_rows(2, 4'b0011, 16'h1234, 4'b0000, 2'd0, 1'b1, 1'b0, 16'h1111);
        add_rows(1, 4'b0011, 16'h1234, 4'b0010, 2'd1, 1'b0, 1'b1, 16'h2222);
        add_rows(7, 4'b0011, 16'h1234, 4'b0010, 2'd1, 1'b0, 1'b0, 16'h2222);
        add_rows(2, 4'b0011, 16'h1234, 4'b0000, 2'd1, 1'b1, 1'b0, 16'h2222);
        add_rows(1, 4'b0011, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b1, 16'h1111);
`endif
        // Early release in dwell, then release with nothing pending
        add_rows(1, 4'b0000, 16'h1234, 4'b0000, 2'd0, 1'b1, 1'b0, 16'h1111);
        add_rows(1, 4'b0010, 16'h1234, 4'b0010, 2'd1, 1'b0, 1'b1, 16'h2222);
        add_rows(2, 4'b0010, 16'h1234, 4'b0010, 2'd1, 1'b0, 1'b0, 16'h2222);
        add_rows(2, 4'b1000, 16'h1234, 4'b0000, 2'd1, 1'b1, 1'b0, 16'h2222);
        add_rows(1, 4'b1000, 16'h1234, 4'b1000, 2'd3, 1'b0, 1'b1, 16'h3333);
        add_rows(1, 4'b0000, 16'h1234, 4'b0000, 2'd3, 1'b1, 1'b0, 16'h3333);
        // Latched next owner withdraws during blank
        add_rows(1, 4'b0010, 16'h1234, 4'b0010, 2'd1, 1'b0, 1'b1, 16'h2222);
        add_rows(7, 4'b0010, 16'h1234, 4'b0010, 2'd1, 1'b0, 1'b0, 16'h2222);
        add_rows(1, 4'b1110, 16'h1234, 4'b0000, 2'd1, 1'b1, 1'b0, 16'h2222);
        add_rows(1, 4'b1010, 16'h1234, 4'b0000, 2'd1, 1'b1, 1'b0, 16'h2222);
        add_rows(1, 4'b1010, 16'h1234, 4'b1000, 2'd3, 1'b0, 1'b1, 16'h3333);
        add_rows(7, 4'b1000, 16'h1234, 4'b1000, 2'd3, 1'b0, 1'b0, 16'h3333);
        add_rows(1, 4'b1100, 16'h1234, 4'b0000, 2'd3, 1'b1, 1'b0, 16'h3333);
        add_rows(2, 4'b0000, 16'h1234, 4'b0000, 2'd3, 1'b1, 1'b0, 16'h3333);
        add_rows(1, 4'b0001, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b1, 16'h1111);
        // Requester 0 rises while owner 2 is in dwell
        add_rows(1, 4'b0000, 16'h1234, 4'b0000, 2'd0, 1'b1, 1'b0, 16'h1111);
        add_rows(1, 4'b0100, 16'h1234, 4'b0100, 2'd2, 1'b0, 1'b1, 16'h1234);
        add_rows(1, 4'b0100, 16'h1234, 4'b0100, 2'd2, 1'b0, 1'b0, 16'h1234);
`ifdef DISP_SCHED_PRIO_EN
        add_rows(2, 4'b0101, 16'h1234, 4'b0000, 2'd2, 1'b1, 1'b0, 16'h1234);
        add_rows(1, 4'b0101, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b1, 16'h1111);
        add_rows(6, 4'b0101, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b0, 16'h1111);
`else
        add_rows(6, 4'b0101, 16'h1234, 4'b0100, 2'd2, 1'b0, 1'b0, 16'h1234);
        add_rows(2, 4'b0101, 16'h1234, 4'b0000, 2'd2, 1'b1, 1'b0, 16'h1234);
        add_rows(1, 4'b0101, 16'h1234, 4'b0001, 2'd0, 1'b0, 1'b1, 16'h1111);
`endif

        rst         = 1'b0;
        bus.req     = 4'b1111;
        bus.value   = {16'h3333, 16'hBEEF, 16'h2222, 16'h1111};
        bus_b.req   = 3'b000;
        bus_b.value = {16'hCCCC, 16'hBBBB, 16'hAAAA};

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_main("reset_hold", 4'b0000, 2'd0, 1'b1, 1'b0, 16'h0000);
        end
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            @(posedge clk);
            #1;
            check_output(i);
        end

        // Zero-blank instance with three requesters while main owner 0 is held
        bus.req = 4'b0001;
        step_b("b0_first",     3'b110, 3'b010, 1'b1, 16'hBBBB);
        step_b("b0_dwell",     3'b110, 3'b010, 1'b0, 16'hBBBB);
        step_b("b0_direct12",  3'b110, 3'b100, 1'b1, 16'hCCCC);
        step_b("b0_dwell2",    3'b110, 3'b100, 1'b0, 16'hCCCC);
        step_b("b0_wrap21",    3'b110, 3'b010, 1'b1, 16'hBBBB);
        step_b("b0_release",   3'b001, 3'b001, 1'b1, 16'hAAAA);
        step_b("b0_idle",      3'b000, 3'b000, 1'b0, 16'hAAAA);
        check_main("hold_forever", 4'b0001, 2'd0, 1'b0, 1'b0, 16'h1111);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst = 1'b0;
        #2;
        check_main("async_reset", 4'b0000, 2'd0, 1'b1, 1'b0, 16'h0000);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_main("post_reset_grant", 4'b0001, 2'd0, 1'b0, 1'b1, 16'h1111);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares the 4-digit seven-segment display between up to four requesters. Each requester supplies its own 16-bit hex value.
- Round-robin arbiter with a minimum dwell time per owner and a blanking gap between owners, to suppress ghosting.
- Output value and blank flag feed the display digit-scan mux; the scheduler sits upstream of it.

Parameters:
- NREQ, 4, number of requesters, legal range 2..4.
- DWELL, 16'd5000, minimum cycles an owner keeps the display, legal range 1..65535.
- BLANK, 8'd4, blank-gap cycles between owners; 0 means switch directly.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NREQ  request per requester, level-sensitive.
- value  input  16*NREQ  packed values; requester i at [16*i+15:16*i].
- grant  output  NREQ  one-hot current owner; all zero when no owner.
- owner  output  2  index of current or most recent owner.
- disp_value  output  16  value to display.
- disp_blank  output  1  high means the downstream display drives all digits off.
- switch_pulse  output  1  one-cycle strobe when a new owner is granted.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - grant=0, owner=0, disp_value=16'h0000, disp_blank=1, switch_pulse=0.
  - Round-robin pointer=0, dwell counter=0, blank counter=0.
- All outputs are registered.
- disp_value = value[owner] is sampled every cycle while grant!=0, so it tracks live data. It holds its last value while blank.
- Arbitration (RR): search from pointer=(owner+1) mod NREQ upward with wrap; the first asserted req wins. From IDLE after reset the search starts at index 0. Requests at indices >= NREQ do not exist.
- FSM states and transitions:
  - IDLE:
    - grant=0, disp_blank=1.
    - Any req high -> winner latched. Next cycle: grant set, disp_blank=0, switch_pulse=1, enter DWELL with counter=0.
    - Latency from req to grant is 1 cycle.
  - DWELL:
    - Counter increments each cycle. At counter==DWELL-1 go to OPEN.
    - Owner drops req: leave immediately. If other reqs are pending go to BLANK, else go to IDLE.
    - Requests from others are ignored until OPEN.
  - OPEN:
    - Owner keeps grant while its req is high and no other req is high.
    - Any other req high -> RR winner latched as next owner -> BLANK.
    - Owner drops req with none pending -> IDLE.
    - Owner drops req with others pending -> BLANK.
  - BLANK:
    - grant=0, disp_blank=1, blank counter runs BLANK cycles.
    - At the end, if the latched next owner still requests -> grant it, switch_pulse=1, DWELL.
    - Otherwise re-run RR. If there is a winner -> grant it (no extra blank); if none -> IDLE.
- BLANK=0: the BLANK state is bypassed. grant changes directly from old one-hot to new one-hot in a single cycle, with switch_pulse=1.
- A single requester held high forever keeps ownership indefinitely; no forced blanking.
- Simultaneous owner release and other request in the same cycle: treat as a switch (BLANK path).
- Reset asserted mid-operation: everything returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: DISP_SCHED_PRIO_EN.
- Defined:
  - Requester 0 is high priority: it always wins arbitration when its req is high.
  - If req[0] rises while another owner is in DWELL or OPEN, that owner is preempted next cycle, ignoring the dwell. The FSM goes through BLANK (or switches directly if BLANK=0) to owner 0.
  - Owner 0 is never preempted.
- Undefined: pure round-robin as above; requester 0 has no special treatment.

Test Plan (NREQ=4, DWELL=8, BLANK=2):
- Reset: hold rst=0 for 3 cycles with req=4'b1111 -> grant=0, disp_blank=1, disp_value=0. After release, first grant is 4'b0001, one cycle later.
- Single owner: req=4'b0100, value[2]=16'hBEEF -> grant=4'b0100 after 1 cycle, switch_pulse for 1 cycle, disp_value=BEEF held indefinitely. Changing value[2] to 16'h1234 appears on disp_value 1 cycle later.
- Dwell and rotation: req=4'b0011 from IDLE -> owner 0 for exactly 8 cycles, 2 cycles with grant=0 and disp_blank=1, then owner 1 for at least 8 cycles, then back to owner 0.
- Early release: owner 1 drops req in dwell cycle 3 with req[3]=1 -> BLANK for 2 cycles -> grant=4'b1000. With no others pending -> IDLE next cycle.
- Blank-time withdrawal: the latched next owner (2) drops req during BLANK while req[3]=1 -> grant=4'b1000 at end of blank. If req[3]=0 -> IDLE.
- DISP_SCHED_PRIO_EN defined: owner 2 in dwell cycle 2, req[0] rises -> grant=0 next cycle, 2 blank cycles, grant=4'b0001. Undefined: owner 2 completes its 8-cycle dwell first.
